// File: rtl/iob_axi_bridge_if.sv
// Bus bundles for the IOb-to-AXI bridge: an IOb native request port and a
// single-beat AXI4 master port, each with master/slave modports.

interface iob_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic                  valid;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;

    modport master (output valid, addr, wdata, wstrb, input rdata, ready);
    modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

interface axi_if #(
    parameter int ID_W   = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/iob_axi_bridge.sv
// Turns one IOb native request at a time into a single-beat AXI4 write
// (AW+W+B) or read (AR+R); a sticky flag remembers any non-OKAY response.

module iob_axi_bridge #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int AXI_ID_W   = 1,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    iob_if.slave  iob,
    axi_if.master m_axi,
    output logic  err_o
);

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA,
        RESP
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  bready_q, bready_d;
    logic                  rready_q, rready_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;

    logic                  awDone;
    logic                  wDone;
    logic [AXI_ADDR_W-1:0] axiAddr;
    logic                  unusedBits;

    // A channel counts as done once its valid is gone or is being accepted now.
    assign awDone = !awvalid_q || m_axi.awready;
    assign wDone  = !wvalid_q  || m_axi.wready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (iob.valid) state_d = (|iob.wstrb) ? WADDR : RADDR;
            WADDR:   if (awDone && wDone) state_d = WRESP;
            WRESP:   if (m_axi.bvalid) state_d = RESP;
            RADDR:   if (m_axi.arready) state_d = RDATA;
            RDATA:   if (m_axi.rvalid) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields are only loaded in IDLE, so they stay frozen for the whole transaction.
    always_comb begin
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        bready_d  = bready_q;
        rready_d  = rready_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (iob.valid) begin
                    addr_d  = {iob.addr[ADDR_W-1:2], 2'b00};
                    wdata_d = iob.wdata;
                    wstrb_d = iob.wstrb;
                    if (|iob.wstrb) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        arvalid_d = 1'b1;
                    end
                end
            end
            WADDR: begin
                if (m_axi.awready) awvalid_d = 1'b0;
                if (m_axi.wready)  wvalid_d  = 1'b0;
                if (awDone && wDone) bready_d = 1'b1;
            end
            WRESP: begin
                if (m_axi.bvalid) begin
                    bready_d = 1'b0;
                    ready_d  = 1'b1;
                    err_d    = err_q | (m_axi.bresp != 2'b00);
                end
            end
            RADDR: begin
                if (m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RDATA: begin
                if (m_axi.rvalid) begin
                    rdata_d  = m_axi.rdata;
                    rready_d = 1'b0;
                    ready_d  = 1'b1;
                    err_d    = err_q | (m_axi.rresp != 2'b00);
                end
            end
            default: ;
        endcase
    end

    if (AXI_ADDR_W > ADDR_W) begin : g_addrExt
        assign axiAddr = {{(AXI_ADDR_W-ADDR_W){1'b0}}, addr_q};
    end else begin : g_addrTrunc
        assign axiAddr = addr_q[AXI_ADDR_W-1:0];
    end

    assign m_axi.awid    = '0;
    assign m_axi.awaddr  = axiAddr;
    assign m_axi.awlen   = 8'd0;
    assign m_axi.awsize  = 3'd2;
    assign m_axi.awburst = 2'b01;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = 4'b0011;
    assign m_axi.awprot  = 3'd0;
    assign m_axi.awqos   = 4'd0;
    assign m_axi.awvalid = awvalid_q;

    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wlast   = 1'b1;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;

    assign m_axi.arid    = '0;
    assign m_axi.araddr  = axiAddr;
    assign m_axi.arlen   = 8'd0;
    assign m_axi.arsize  = 3'd2;
    assign m_axi.arburst = 2'b01;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = 4'b0011;
    assign m_axi.arprot  = 3'd0;
    assign m_axi.arqos   = 4'd0;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

    assign iob.rdata = rdata_q;
    assign iob.ready = ready_q;
    assign err_o     = err_q;

    // IDs, rlast and the byte offset carry no information for single-beat word accesses.
    assign unusedBits = ^{m_axi.bid, m_axi.rid, m_axi.rlast, iob.addr[1:0]};

endmodule

// File: tb/tb_iob_axi_bridge.sv
// Bench for iob_axi_bridge: the bench plays both IOb master and AXI memory
// slave, predicting latency, beats, read data and the error flag from a word memory.

module tb_iob_axi_bridge;

    logic clk = 1'b0;
    logic rstN;
    logic errOut;
    int   assertCount = 0;
    int   failCount   = 0;
    logic expErr;
    logic [31:0] mem [logic [31:0]];

    iob_if #(.ADDR_W(32), .DATA_W(32)) iobBus ();
    axi_if #(.ID_W(1), .ADDR_W(32), .DATA_W(32)) axiBus ();

    iob_axi_bridge #(
        .ADDR_W(32), .DATA_W(32), .AXI_ID_W(1), .AXI_ADDR_W(32), .AXI_DATA_W(32)
    ) dut (
        .clk_i (clk),
        .rst_ni(rstN),
        .iob   (iobBus),
        .m_axi (axiBus),
        .err_o (errOut)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] outVector();
        return {axiBus.awvalid, axiBus.wvalid, axiBus.arvalid, axiBus.bready,
                axiBus.rready, iobBus.ready, errOut, |iobBus.rdata};
    endfunction

    task automatic driveSlaveIdle();
        axiBus.awready = 1'b0;
        axiBus.wready  = 1'b0;
        axiBus.arready = 1'b0;
        axiBus.bvalid  = 1'b0;
        axiBus.bresp   = 2'b00;
        axiBus.bid     = 1'b0;
        axiBus.rvalid  = 1'b0;
        axiBus.rdata   = 32'h0;
        axiBus.rresp   = 2'b00;
        axiBus.rid     = 1'b0;
        axiBus.rlast   = 1'b0;
    endtask

    // One IOb request; d1 = AW/AR accept delay, d2 = W accept or R data delay, d3 = B delay.
    task automatic applyStimulus(input bit isWrite, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, input int d1, input int d2, input int d3,
                                 input logic [1:0] resp, input bit holdResp);
        int expLat, readyCyc, readyCnt, awCnt, wCnt, arCnt, bCnt, rCnt, awHs, wHs, arHs, earlyB;
        logic [31:0] wordAddr, expRdata, cur;
        bit dropNext;
        wordAddr = {addr[31:2], 2'b00};
        expLat   = isWrite ? 3 + ((d1 > d2) ? d1 : d2) + d3 : 3 + d1 + d2;
        expRdata = mem.exists(wordAddr) ? mem[wordAddr] : 32'h0;
        if (resp != 2'b00) expErr = 1'b1;
        readyCyc = -1; readyCnt = 0; awCnt = 0; wCnt = 0; arCnt = 0; bCnt = 0; rCnt = 0;
        awHs = -1; wHs = -1; arHs = -1; earlyB = 0; dropNext = 1'b0;
        iobBus.valid = 1'b1;
        iobBus.addr  = addr;
        iobBus.wdata = wdata;
        iobBus.wstrb = isWrite ? wstrb : 4'h0;
        for (int c = 0; c <= expLat + 3; c++) begin
            if (dropNext) begin
                iobBus.valid = 1'b0;
                dropNext = 1'b0;
            end
            if (c > 0 && iobBus.ready) begin
                readyCnt++;
                if (readyCyc < 0) begin
                    readyCyc = c;
                    if (!isWrite) checkOutput("rdata", iobBus.rdata, expRdata);
                    checkOutput("err", errOut, expErr);
                    if (holdResp) dropNext = 1'b1;
                    else iobBus.valid = 1'b0;
                end
            end
            if (axiBus.bready && (awCnt == 0 || wCnt == 0)) earlyB++;

            axiBus.awready = isWrite && c >= 1 + d1;
            axiBus.wready  = isWrite && c >= 1 + d2;
            axiBus.arready = !isWrite && c >= 1 + d1;
            axiBus.bvalid  = awCnt == 1 && wCnt == 1 && bCnt == 0 && c >= ((awHs > wHs) ? awHs : wHs) + 1 + d3;
            axiBus.bresp   = axiBus.bvalid ? resp : 2'($urandom);
            axiBus.bid     = 1'($urandom);
            axiBus.rvalid  = arCnt == 1 && rCnt == 0 && c >= arHs + 1 + d2;
            axiBus.rdata   = axiBus.rvalid ? expRdata : $urandom;
            axiBus.rresp   = axiBus.rvalid ? resp : 2'($urandom);
            axiBus.rlast   = axiBus.rvalid;
            axiBus.rid     = 1'($urandom);

            if (axiBus.awvalid) begin
                checkOutput("awaddr", axiBus.awaddr, wordAddr);
                checkOutput("awFields", {axiBus.awlen, axiBus.awsize, axiBus.awburst, axiBus.awlock,
                            axiBus.awcache, axiBus.awprot, axiBus.awqos, axiBus.awid},
                            {8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 1'b0});
                if (axiBus.awready) begin
                    awCnt++;
                    awHs = c;
                end
            end
            if (axiBus.wvalid) begin
                checkOutput("wBeat", {axiBus.wdata, axiBus.wstrb, axiBus.wlast}, {wdata, wstrb, 1'b1});
                if (axiBus.wready) begin
                    wCnt++;
                    wHs = c;
                    cur = mem.exists(wordAddr) ? mem[wordAddr] : 32'h0;
                    for (int b = 0; b < 4; b++) if (wstrb[b]) cur[8*b +: 8] = wdata[8*b +: 8];
                    mem[wordAddr] = cur;
                end
            end
            if (axiBus.arvalid) begin
                checkOutput("araddr", axiBus.araddr, wordAddr);
                checkOutput("arFields", {axiBus.arlen, axiBus.arsize, axiBus.arburst, axiBus.arlock,
                            axiBus.arcache, axiBus.arprot, axiBus.arqos, axiBus.arid},
                            {8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 1'b0});
                if (axiBus.arready) begin
                    arCnt++;
                    arHs = c;
                end
            end
            if (axiBus.bvalid && axiBus.bready) bCnt++;
            if (axiBus.rvalid && axiBus.rready) rCnt++;

            // Disturbing the request mid-flight must not affect the transaction.
            if (c >= 1 && readyCyc < 0) begin
                iobBus.addr  = $urandom;
                iobBus.wdata = $urandom;
                iobBus.wstrb = 4'($urandom);
            end
            @(posedge clk);
            #1;
        end
        iobBus.valid = 1'b0;
        driveSlaveIdle();
        checkOutput("readyPulses", readyCnt, 1);
        checkOutput("latency", readyCyc, expLat);
        checkOutput("awBeats", awCnt, isWrite ? 1 : 0);
        checkOutput("wBeats", wCnt, isWrite ? 1 : 0);
        checkOutput("bBeats", bCnt, isWrite ? 1 : 0);
        checkOutput("arBeats", arCnt, isWrite ? 0 : 1);
        checkOutput("rBeats", rCnt, isWrite ? 0 : 1);
        checkOutput("earlyBready", earlyB, 0);
    endtask

    task automatic resetMidWrite();
        iobBus.valid = 1'b1;
        iobBus.addr  = 32'h300;
        iobBus.wdata = 32'hCAFE0300;
        iobBus.wstrb = 4'hF;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("awPendingBeforeReset", {axiBus.awvalid, axiBus.wvalid}, 2'b11);
        #3 rstN = 1'b0;
        #1;
        checkOutput("resetAsync", outVector(), 8'h00);
        iobBus.valid = 1'b0;
        expErr = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("resetHeld", outVector(), 8'h00);
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstN = 1'b0;
        expErr = 1'b0;
        iobBus.valid = 1'b0;
        iobBus.addr  = 32'h0;
        iobBus.wdata = 32'h0;
        iobBus.wstrb = 4'h0;
        driveSlaveIdle();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetState", outVector(), 8'h00);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 1'b0);
        mem[32'h204] = 32'h12345678;
        applyStimulus(1'b0, 32'h204, 32'h0, 4'h0, 2, 3, 0, 2'b00, 1'b0);
        applyStimulus(1'b1, 32'h108, 32'hA5A50001, 4'h3, 1, 0, 0, 2'b00, 1'b0);
        applyStimulus(1'b1, 32'h10C, 32'h5A5A0002, 4'hC, 0, 1, 1, 2'b00, 1'b0);
        applyStimulus(1'b0, 32'h103, 32'h0, 4'h0, 0, 0, 0, 2'b00, 1'b0);
        applyStimulus(1'b0, 32'h204, 32'h0, 4'h0, 1, 1, 0, 2'b10, 1'b0);
        applyStimulus(1'b1, 32'h110, 32'h0BADF00D, 4'hF, 0, 0, 0, 2'b00, 1'b0);
        applyStimulus(1'b1, 32'h114, 32'h11223344, 4'hF, 0, 0, 0, 2'b00, 1'b1);
        resetMidWrite();
        applyStimulus(1'b0, 32'h100, 32'h0, 4'h0, 0, 0, 0, 2'b00, 1'b0);

        for (int i = 0; i < 40; i++) begin
            bit          isWrite;
            logic [31:0] addr;
            logic [1:0]  resp;
            isWrite = 1'($urandom_range(0, 1));
            addr    = 32'h1000 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            resp    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            applyStimulus(isWrite, addr, $urandom, 4'($urandom_range(1, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                          resp, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
